// File: rtl/timer_service_master.sv
// -----------------------------------------------------------------------------
// timer_service_master
//
// Avalon-MM master that services the 16-bit interval-timer slave on behalf of
// a host command port. It programs the period, starts the timer, acknowledges
// every timeout interrupt and can stop the timer on request. This removes the
// need for software timer servicing in datapaths that have no CPU.
//
// Optional build feature, selected by the macro TIMER_SNAP_EN:
//   After every serviced timeout the master also requests a counter snapshot
//   and reads it back into snap_value, pulsing snap_valid. When the macro is
//   not defined, snap_value and snap_valid are tied to zero.
//
// Parameters:
//   CNT_W       width of the saturating tick counter
//   TICK_LIMIT  continuous mode: stop after this many ticks (0 = unlimited)
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cmd_valid/ready   host start handshake (ready only while idle)
//   cmd_period        32-bit period written to the slave as {hi,lo}
//   cmd_continuous    1 = continuous, 0 = one-shot
//   cmd_stop          level abort request, sampled every cycle
//   busy              high whenever a command is in progress
//   tick              one-cycle pulse per serviced timeout
//   tick_count        ticks since the last accepted command
//   snap_value/valid  last counter snapshot and its update strobe
//   av_*              Avalon-MM master towards the timer s1 slave
// -----------------------------------------------------------------------------
module timer_service_master #(
    parameter int CNT_W      = 16,
    parameter int TICK_LIMIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_period,
    input  logic             cmd_continuous,
    input  logic             cmd_stop,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [31:0]      snap_value,
    output logic             snap_valid,
    output logic [2:0]       av_address,
    output logic             av_chipselect,
    output logic             av_write_n,
    output logic [15:0]      av_writedata,
    input  logic [15:0]      av_readdata,
    input  logic             av_irq
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TICK_LIMIT);

    // Slave register map and control word values.
    localparam logic [2:0]  A_STATUS  = 3'd0;
    localparam logic [2:0]  A_CONTROL = 3'd1;
    localparam logic [2:0]  A_PERL    = 3'd2;
    localparam logic [2:0]  A_PERH    = 3'd3;
    localparam logic [15:0] CTRL_CONT = 16'h0007;  // START|CONT|ITO
    localparam logic [15:0] CTRL_ONE  = 16'h0005;  // START|ITO
    localparam logic [15:0] CTRL_STOP = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PERL,
        S_WR_PERH,
        S_WR_CTRL,
        S_WAIT_IRQ,
        S_CLR,
        S_GAP,
        S_STOP,
        S_STCLR
`ifdef TIMER_SNAP_EN
        ,
        S_SNAPW,
        S_RDL,
        S_RDH,
        S_RDCAP
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    state_t             w_exit_state;
    logic               w_accept;

    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_tick;
    logic [CNT_W-1:0]   r_tick_count;
    logic [15:0]        r_period_hi;
    logic               r_cont;
    logic [2:0]         r_av_address;
    logic               r_av_chipselect;
    logic               r_av_write_n;
    logic [15:0]        r_av_writedata;

    assign w_accept = cmd_valid && r_cmd_ready;

    // Decision taken once a timeout has been fully serviced.
    always_comb begin
        w_exit_state = S_WAIT_IRQ;
        if (!r_cont)
            w_exit_state = S_IDLE;
        else if (TICK_LIMIT != 0 && r_tick_count == LIMIT)
            w_exit_state = S_STOP;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_next = S_WR_PERL;
            S_WR_PERL:  w_state_next = S_WR_PERH;
            S_WR_PERH:  w_state_next = S_WR_CTRL;
            S_WR_CTRL:  w_state_next = S_WAIT_IRQ;
            S_WAIT_IRQ: if (av_irq) w_state_next = S_CLR;
            S_CLR:      w_state_next = S_GAP;
`ifdef TIMER_SNAP_EN
            S_GAP:      w_state_next = S_SNAPW;
            S_SNAPW:    w_state_next = S_RDL;
            S_RDL:      w_state_next = S_RDH;
            S_RDH:      w_state_next = S_RDCAP;
            S_RDCAP:    w_state_next = w_exit_state;
`else
            S_GAP:      w_state_next = w_exit_state;
`endif
            S_STOP:     w_state_next = S_STCLR;
            S_STCLR:    w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
        // An abort lets the current bus cycle finish and then diverts to the
        // stop sequence; it also beats a simultaneous irq in WAIT_IRQ.
        if (cmd_stop && r_state != S_IDLE && r_state != S_STOP && r_state != S_STCLR)
            w_state_next = S_STOP;
    end

    // All outputs are registered and decoded from the state being entered,
    // so the bus fields line up exactly with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cmd_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_tick          <= 1'b0;
            r_tick_count    <= '0;
            r_period_hi     <= '0;
            r_cont          <= 1'b0;
            r_av_address    <= '0;
            r_av_chipselect <= 1'b0;
            r_av_write_n    <= 1'b1;
            r_av_writedata  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_busy      <= (w_state_next != S_IDLE);
            r_tick      <= (w_state_next == S_CLR);

            if (w_accept) begin
                r_period_hi  <= cmd_period[31:16];
                r_cont       <= cmd_continuous;
                r_tick_count <= '0;
            end else if (w_state_next == S_CLR && r_tick_count != {CNT_W{1'b1}}) begin
                r_tick_count <= r_tick_count + 1'b1;
            end

            r_av_address    <= '0;
            r_av_chipselect <= 1'b0;
            r_av_write_n    <= 1'b1;
            r_av_writedata  <= '0;
            case (w_state_next)
                S_WR_PERL: begin
                    // Only reachable from an accept, so take the live port.
                    r_av_address    <= A_PERL;
                    r_av_chipselect <= 1'b1;
                    r_av_write_n    <= 1'b0;
                    r_av_writedata  <= cmd_period[15:0];
                end
                S_WR_PERH: begin
                    r_av_address    <= A_PERH;
                    r_av_chipselect <= 1'b1;
                    r_av_write_n    <= 1'b0;
                    r_av_writedata  <= r_period_hi;
                end
                S_WR_CTRL: begin
                    r_av_address    <= A_CONTROL;
                    r_av_chipselect <= 1'b1;
                    r_av_write_n    <= 1'b0;
                    r_av_writedata  <= r_cont ? CTRL_CONT : CTRL_ONE;
                end
                S_CLR, S_STCLR: begin
                    r_av_address    <= A_STATUS;
                    r_av_chipselect <= 1'b1;
                    r_av_write_n    <= 1'b0;
                end
                S_STOP: begin
                    r_av_address    <= A_CONTROL;
                    r_av_chipselect <= 1'b1;
                    r_av_write_n    <= 1'b0;
                    r_av_writedata  <= CTRL_STOP;
                end
`ifdef TIMER_SNAP_EN
                S_SNAPW: begin
                    r_av_address    <= 3'd4;
                    r_av_chipselect <= 1'b1;
                    r_av_write_n    <= 1'b0;
                end
                S_RDL: begin
                    r_av_address    <= 3'd4;
                    r_av_chipselect <= 1'b1;
                end
                S_RDH: begin
                    r_av_address    <= 3'd5;
                    r_av_chipselect <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef TIMER_SNAP_EN
    logic [31:0] r_snap_value;
    logic        r_snap_valid;

    // Read latency is one cycle: the RDL data arrives during RDH and the RDH
    // data arrives during the following bus-idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_value <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= 1'b0;
            if (r_state == S_RDH)
                r_snap_value[15:0] <= av_readdata;
            if (r_state == S_RDCAP) begin
                r_snap_value[31:16] <= av_readdata;
                r_snap_valid        <= 1'b1;
            end
        end
    end

    assign snap_value = r_snap_value;
    assign snap_valid = r_snap_valid;
`else
    logic w_unused_readdata;
    assign w_unused_readdata = ^av_readdata;
    assign snap_value = '0;
    assign snap_valid = 1'b0;
`endif

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign tick          = r_tick;
    assign tick_count    = r_tick_count;
    assign av_address    = r_av_address;
    assign av_chipselect = r_av_chipselect;
    assign av_write_n    = r_av_write_n;
    assign av_writedata  = r_av_writedata;

endmodule

// File: tb/tb_timer_service_master.sv
module tb_timer_service_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic        cmd_stop;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_irq;

    always #5 clk = ~clk;

    timer_service_master #(.CNT_W(16), .TICK_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
        .cmd_stop(cmd_stop), .busy(busy), .tick(tick),
        .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid),
        .av_address(av_address), .av_chipselect(av_chipselect),
        .av_write_n(av_write_n), .av_writedata(av_writedata),
        .av_readdata(av_readdata), .av_irq(av_irq)
    );

    // ---------------- interval timer slave model ----------------
    localparam logic [31:0] SNAP_SRC = 32'h0001_2345;
    logic [31:0] s_per, s_cnt, s_snap;
    logic        s_run, s_cont, s_ito, s_to;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_per <= '0; s_cnt <= '0; s_snap <= '0;
            s_run <= 1'b0; s_cont <= 1'b0; s_ito <= 1'b0; s_to <= 1'b0;
            av_irq <= 1'b0; av_readdata <= '0;
        end else begin
            av_irq <= s_to & s_ito;
            if (s_run) begin
                if (s_cnt == 0) begin
                    s_to  <= 1'b1;
                    s_cnt <= s_per;
                    if (!s_cont) s_run <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
            if (av_chipselect && !av_write_n) begin
                case (av_address)
                    3'd0: s_to <= 1'b0;
                    3'd1: begin
                        if (av_writedata[3]) s_run <= 1'b0;
                        else if (av_writedata[0]) begin
                            s_run  <= 1'b1;
                            s_cnt  <= s_per;
                            s_cont <= av_writedata[1];
                            s_ito  <= av_writedata[2];
                        end
                    end
                    3'd2: begin s_per[15:0]  <= av_writedata; s_run <= 1'b0; end
                    3'd3: begin s_per[31:16] <= av_writedata; s_run <= 1'b0; end
                    3'd4: s_snap <= SNAP_SRC;
                    default: ;
                endcase
            end
            if (av_chipselect && av_write_n) begin
                case (av_address)
                    3'd4:    av_readdata <= s_snap[15:0];
                    3'd5:    av_readdata <= s_snap[31:16];
                    default: av_readdata <= s_cnt[15:0];
                endcase
            end
        end
    end

    // ---------------- bus / pulse monitor ----------------
    typedef struct {
        int          cyc;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    int   cyc = 0;
    acc_t alog[$];
    int   n_ticks = 0;
    int   n_snaps = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic acc_t mk_acc(int c, logic we, logic [2:0] a, logic [15:0] d);
        acc_t r;
        r.cyc = c; r.we = we; r.addr = a; r.data = d;
        return r;
    endfunction

    always @(negedge clk) begin
        if (av_chipselect)
            alog.push_back(mk_acc(cyc, !av_write_n, av_address, av_write_n ? 16'h0 : av_writedata));
        if (tick)       n_ticks <= n_ticks + 1;
        if (snap_valid) n_snaps <= n_snaps + 1;
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [19:0] rd(input logic [2:0] a);
        return {1'b0, a, 16'h0000};
    endfunction

    // Accesses following each serviced timeout.
    task automatic exp_tick();
        exp_q.push_back(wr(3'd0, 16'h0000));
`ifdef TIMER_SNAP_EN
        exp_q.push_back(wr(3'd4, 16'h0000));
        exp_q.push_back(rd(3'd4));
        exp_q.push_back(rd(3'd5));
`endif
    endtask

    task automatic compare_log(input string tag, input int base);
        check({tag, "_len"}, alog.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            if (base + i < alog.size())
                check($sformatf("%s_acc%0d", tag, i),
                      {12'h0, alog[base+i].we, alog[base+i].addr, alog[base+i].data},
                      {12'h0, exp_q[i]});
        end
    endtask

    task automatic send_cmd(input logic [31:0] p, input logic c, output int acc);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_period = p; cmd_continuous = c;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmd_ready !== 1'b1 && n < bound);
        check({tag, "_idle"}, {31'b0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base, t0, s0, acc, n, gap;
        logic found;

        reset = 1'b1; cmd_valid = 1'b0; cmd_period = '0;
        cmd_continuous = 1'b0; cmd_stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  {31'b0, cmd_ready},     32'd1);
        check("rst_busy",   {31'b0, busy},          32'd0);
        check("rst_tick",   {31'b0, tick},          32'd0);
        check("rst_count",  {16'b0, tick_count},    32'd0);
        check("rst_snap",   snap_value,             32'd0);
        check("rst_snapv",  {31'b0, snap_valid},    32'd0);
        check("rst_cs",     {31'b0, av_chipselect}, 32'd0);
        check("rst_wn",     {31'b0, av_write_n},    32'd1);
        check("rst_addr",   {29'b0, av_address},    32'd0);
        check("rst_wdata",  {16'b0, av_writedata},  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // A: one-shot, period 0x31
        base = alog.size(); t0 = n_ticks; s0 = n_snaps;
        exp_q.delete();
        exp_q.push_back(wr(3'd2, 16'h0031));
        exp_q.push_back(wr(3'd3, 16'h0000));
        exp_q.push_back(wr(3'd1, 16'h0005));
        exp_tick();
        send_cmd(32'h0000_0031, 1'b0, acc);
        wait_idle("a", 300);
        compare_log("a", base);
        if (alog.size() >= base + 4) begin
            check("a_start_cyc", alog[base].cyc, acc);
            check("a_perh_cyc",  alog[base+1].cyc - alog[base].cyc, 32'd1);
            check("a_ctrl_cyc",  alog[base+2].cyc - alog[base].cyc, 32'd2);
            gap = alog[base+3].cyc - alog[base+2].cyc;
            check("a_clr_gap_45_60", {31'b0, (gap >= 45 && gap <= 60)}, 32'd1);
        end
        check("a_ticks", n_ticks - t0, 32'd1);
        check("a_count", {16'b0, tick_count}, 32'd1);
        check("a_busy",  {31'b0, busy}, 32'd0);
`ifdef TIMER_SNAP_EN
        check("a_snap",   snap_value, 32'h0001_2345);
        check("a_snapv",  n_snaps - s0, 32'd1);
`else
        check("a_snap",   snap_value, 32'd0);
        check("a_snapv",  n_snaps - s0, 32'd0);
`endif

        // B: continuous, TICK_LIMIT = 3, period 10
        base = alog.size(); t0 = n_ticks;
        exp_q.delete();
        exp_q.push_back(wr(3'd2, 16'h000A));
        exp_q.push_back(wr(3'd3, 16'h0000));
        exp_q.push_back(wr(3'd1, 16'h0007));
        repeat (3) exp_tick();
        exp_q.push_back(wr(3'd1, 16'h0008));
        exp_q.push_back(wr(3'd0, 16'h0000));
        send_cmd(32'h0000_000A, 1'b1, acc);
        wait_idle("b", 600);
        compare_log("b", base);
        check("b_ticks", n_ticks - t0, 32'd3);
        check("b_count", {16'b0, tick_count}, 32'd3);
        repeat (40) @(negedge clk);
        check("b_ticks_after", n_ticks - t0, 32'd3);
        check("b_irq_after",   {31'b0, av_irq}, 32'd0);

        // C: abort during WR_PERH
        base = alog.size(); t0 = n_ticks;
        exp_q.delete();
        exp_q.push_back(wr(3'd2, 16'h0005));
        exp_q.push_back(wr(3'd3, 16'h0002));
        exp_q.push_back(wr(3'd1, 16'h0008));
        exp_q.push_back(wr(3'd0, 16'h0000));
        send_cmd(32'h0002_0005, 1'b1, acc);
        @(posedge clk); #1;
        cmd_stop = 1'b1;
        @(negedge clk);
        check("c_perh_addr", {29'b0, av_address}, 32'd3);
        @(posedge clk); #1;
        cmd_stop = 1'b0;
        wait_idle("c", 50);
        compare_log("c", base);
        check("c_ticks", n_ticks - t0, 32'd0);
        check("c_count", {16'b0, tick_count}, 32'd0);
        check("c_busy",  {31'b0, busy}, 32'd0);

        // D: irq and stop in the same WAIT_IRQ cycle
        base = alog.size(); t0 = n_ticks;
        exp_q.delete();
        exp_q.push_back(wr(3'd2, 16'h000A));
        exp_q.push_back(wr(3'd3, 16'h0000));
        exp_q.push_back(wr(3'd1, 16'h0007));
        exp_tick();
        exp_q.push_back(wr(3'd1, 16'h0008));
        exp_q.push_back(wr(3'd0, 16'h0000));
        send_cmd(32'h0000_000A, 1'b1, acc);
        n = 0;
        while (tick !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("d_first_tick", {31'b0, tick}, 32'd1);
        while (av_irq !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        while (av_irq !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("d_irq_seen", {31'b0, av_irq}, 32'd1);
        cmd_stop = 1'b1;
        @(posedge clk); #1;
        cmd_stop = 1'b0;
        wait_idle("d", 50);
        compare_log("d", base);
        check("d_ticks", n_ticks - t0, 32'd1);
        check("d_count", {16'b0, tick_count}, 32'd1);
        repeat (5) @(negedge clk);
        check("d_irq_after", {31'b0, av_irq}, 32'd0);

        // E: reset mid-operation, then a clean restart
        send_cmd(32'h0000_0031, 1'b0, acc);
        n = 0; found = 1'b0;
        while (!found && n < 300) begin
            @(negedge clk); n++;
`ifdef TIMER_SNAP_EN
            found = av_chipselect && av_write_n && av_address == 3'd4;
`else
            found = av_chipselect && !av_write_n && av_address == 3'd1;
`endif
        end
        check("e_reached", {31'b0, found}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("e_cs",    {31'b0, av_chipselect}, 32'd0);
        check("e_wn",    {31'b0, av_write_n},    32'd1);
        check("e_busy",  {31'b0, busy},          32'd0);
        check("e_ready", {31'b0, cmd_ready},     32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        base = alog.size(); t0 = n_ticks;
        exp_q.delete();
        exp_q.push_back(wr(3'd2, 16'h0031));
        exp_q.push_back(wr(3'd3, 16'h0000));
        exp_q.push_back(wr(3'd1, 16'h0005));
        exp_tick();
        send_cmd(32'h0000_0031, 1'b0, acc);
        wait_idle("e", 300);
        compare_log("e", base);
        if (alog.size() > base)
            check("e_start_cyc", alog[base].cyc, acc);
        check("e_ticks", n_ticks - t0, 32'd1);
        check("e_count", {16'b0, tick_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
